// File: rtl/ddr4_v2_2_20_axi_pkg.sv
// Shared AXI width helpers: log2 and the wide/narrow ratio derivation,
// plus the downsizer's state encoding.
package ddr4_v2_2_20_axi_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } wd_state_e;

  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int ratio(input int s_width, input int m_width);
    return s_width / m_width;
  endfunction

  function automatic int ratio_log(input int s_width, input int m_width);
    return log2(ratio(s_width, m_width));
  endfunction

endpackage

// File: rtl/ddr4_v2_2_20_comparator.sv
// Equality comparator built as a carry chain: the carry survives to the
// top only while every bit pair matches.
module ddr4_v2_2_20_comparator #(
  parameter     C_FAMILY     = "virtex6",
  parameter int C_DATA_WIDTH = 4
) (
  input  logic                    cin_i,
  input  logic [C_DATA_WIDTH-1:0] a_i,
  input  logic [C_DATA_WIDTH-1:0] b_i,
  output logic                    cout_o
);

  logic carry;

  always_comb begin
    carry = cin_i;
    for (int i = 0; i < C_DATA_WIDTH; i++) begin
      carry = carry & (a_i[i] ~^ b_i[i]);
    end
    cout_o = carry;
  end

endmodule

// File: rtl/ddr4_v2_2_20_w_downsizer.sv
// AXI W-channel downsizer: holds one wide beat and streams it out as
// narrow slices, starting at the command's sub-word offset.
module ddr4_v2_2_20_w_downsizer
  import ddr4_v2_2_20_axi_pkg::*;
#(
  parameter           C_FAMILY       = "virtex6",
  parameter int       C_S_DATA_WIDTH = 128,
  parameter int       C_M_DATA_WIDTH = 32,
  localparam int      C_RATIO        = ratio(C_S_DATA_WIDTH, C_M_DATA_WIDTH),
  localparam int      C_RATIO_LOG    = ratio_log(C_S_DATA_WIDTH, C_M_DATA_WIDTH)
) (
  input  logic                        ACLK,
  input  logic                        ARESET,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [7:0]                  cmd_len,
  input  logic [C_RATIO_LOG-1:0]      cmd_offset,
  input  logic [C_S_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                        S_AXI_WLAST,
  input  logic                        S_AXI_WVALID,
  output logic                        S_AXI_WREADY,
  output logic [C_M_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                        M_AXI_WLAST,
  output logic                        M_AXI_WVALID,
  input  logic                        M_AXI_WREADY,
  output logic                        wlast_err
);

  wd_state_e                   state_q, state_d;
  logic                        cmd_en_q;
  logic [7:0]                  beat_cnt_q;
  logic [C_RATIO_LOG-1:0]      idx_q;
  logic                        buf_valid_q;
  logic [C_S_DATA_WIDTH-1:0]   buf_data_q;
  logic [C_S_DATA_WIDTH/8-1:0] buf_strb_q;
  logic                        wlast_err_q;

  logic                        idx_at_end, cnt_zero, m_last, release_w;
  logic                        cmd_hs, m_hs, s_hs, wide_last;
  logic [7:0]                  cnt_eff;
  logic [C_RATIO_LOG-1:0]      idx_eff;

  ddr4_v2_2_20_comparator #(
    .C_FAMILY    (C_FAMILY),
    .C_DATA_WIDTH(C_RATIO_LOG)
  ) u_idx_cmp (
    .cin_i (1'b1),
    .a_i   (idx_q),
    .b_i   ({C_RATIO_LOG{1'b1}}),
    .cout_o(idx_at_end)
  );

  ddr4_v2_2_20_comparator #(
    .C_FAMILY    (C_FAMILY),
    .C_DATA_WIDTH(8)
  ) u_cnt_cmp (
    .cin_i (1'b1),
    .a_i   (beat_cnt_q),
    .b_i   (8'd0),
    .cout_o(cnt_zero)
  );

  assign m_last    = (state_q == ST_ACTIVE) & cnt_zero;
  assign release_w = idx_at_end | m_last;
  assign m_hs      = buf_valid_q & M_AXI_WREADY;
  assign cmd_hs    = cmd_valid & cmd_ready;
  assign s_hs      = S_AXI_WVALID & S_AXI_WREADY;

  // A wide beat loaded alongside a narrow handshake starts from the
  // post-handshake count/index, so judge its lastness from those values.
  assign cnt_eff   = m_hs ? beat_cnt_q - 8'd1 : beat_cnt_q;
  assign idx_eff   = m_hs ? idx_q + C_RATIO_LOG'(1) : idx_q;
  assign wide_last = (32'(cnt_eff) <= (32'(C_RATIO - 1) - 32'(idx_eff)));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cmd_hs) state_d = ST_ACTIVE;
      ST_ACTIVE: if (m_hs && m_last) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready    = (state_q == ST_IDLE) & cmd_en_q;
    S_AXI_WREADY = (state_q == ST_ACTIVE) &
                   (~buf_valid_q | (m_hs & release_w & ~m_last));
    M_AXI_WVALID = buf_valid_q;
    M_AXI_WLAST  = m_last;
    M_AXI_WDATA  = buf_data_q[idx_q*C_M_DATA_WIDTH +: C_M_DATA_WIDTH];
    M_AXI_WSTRB  = buf_strb_q[idx_q*(C_M_DATA_WIDTH/8) +: (C_M_DATA_WIDTH/8)];
    wlast_err    = wlast_err_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      cmd_en_q    <= 1'b0;
      beat_cnt_q  <= 8'd0;
      idx_q       <= '0;
      buf_valid_q <= 1'b0;
      wlast_err_q <= 1'b0;
    end else begin
      cmd_en_q <= 1'b1;
      if (cmd_hs) begin
        beat_cnt_q <= cmd_len;
        idx_q      <= cmd_offset;
      end else if (m_hs) begin
        beat_cnt_q <= beat_cnt_q - 8'd1;
        idx_q      <= idx_q + C_RATIO_LOG'(1);
      end
      if (s_hs)                  buf_valid_q <= 1'b1;
      else if (m_hs & release_w) buf_valid_q <= 1'b0;
      if (s_hs && (S_AXI_WLAST != wide_last)) wlast_err_q <= 1'b1;
    end
  end

  // NOTE: the payload register has no reset; buf_valid_q alone qualifies it.
  always_ff @(posedge ACLK) begin
    if (s_hs) begin
      buf_data_q <= S_AXI_WDATA;
      buf_strb_q <= S_AXI_WSTRB;
    end
  end

endmodule

// File: tb/tb_ddr4_v2_2_20_w_downsizer.sv
// Self-checking bench for the 128->32 W downsizer: random data/strobes,
// expected narrow beats derived from burst offset/length arithmetic.
module tb_ddr4_v2_2_20_w_downsizer;

  localparam int SW = 128;
  localparam int MW = 32;
  localparam int R  = SW / MW;

  logic            ACLK = 1'b0;
  logic            ARESET;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [7:0]      cmd_len;
  logic [1:0]      cmd_offset;
  logic [SW-1:0]   S_AXI_WDATA;
  logic [SW/8-1:0] S_AXI_WSTRB;
  logic            S_AXI_WLAST;
  logic            S_AXI_WVALID;
  logic            S_AXI_WREADY;
  logic [MW-1:0]   M_AXI_WDATA;
  logic [MW/8-1:0] M_AXI_WSTRB;
  logic            M_AXI_WLAST;
  logic            M_AXI_WVALID;
  logic            M_AXI_WREADY;
  logic            wlast_err;

  always #5 ACLK = ~ACLK;

  ddr4_v2_2_20_w_downsizer #(
    .C_FAMILY      ("virtex6"),
    .C_S_DATA_WIDTH(SW),
    .C_M_DATA_WIDTH(MW)
  ) dut (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_len     (cmd_len),
    .cmd_offset  (cmd_offset),
    .S_AXI_WDATA (S_AXI_WDATA),
    .S_AXI_WSTRB (S_AXI_WSTRB),
    .S_AXI_WLAST (S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY),
    .M_AXI_WDATA (M_AXI_WDATA),
    .M_AXI_WSTRB (M_AXI_WSTRB),
    .M_AXI_WLAST (M_AXI_WLAST),
    .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY),
    .wlast_err   (wlast_err)
  );

  int errors = 0;
  int checks = 0;
  bit exp_err = 1'b0;
  int s_cyc[$];
  int m_cyc[$];
  int first_cyc;
  int n_beats;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
    check({tag, "_s_wready"}, S_AXI_WREADY, 0);
    check({tag, "_m_wvalid"}, M_AXI_WVALID, 0);
    check({tag, "_m_wlast"}, M_AXI_WLAST, 0);
    check({tag, "_wlast_err"}, wlast_err, 0);
  endtask

  task automatic check_idle(input string tag);
    @(negedge ACLK);
    S_AXI_WVALID = 1'b0;
    S_AXI_WLAST  = 1'b0;
    #1;
    check({tag, "_idle_cmd_ready"}, cmd_ready, 1);
    check({tag, "_idle_m_wvalid"}, M_AXI_WVALID, 0);
    check({tag, "_idle_s_wready"}, S_AXI_WREADY, 0);
    check({tag, "_wlast_err"}, wlast_err, exp_err);
  endtask

  // rmode: 0 always ready, 1 alternate starting ready at first WVALID, 2 random.
  task automatic run_burst(input string tag, input int len, input int off, input int rmode,
                           input bit bad_wlast, input int abort_after);
    logic [SW-1:0]   wd[$];
    logic [SW/8-1:0] ws[$];
    logic [MW-1:0]   ed[$];
    logic [MW/8-1:0] es[$];
    bit              el[$];
    logic [SW-1:0]   tw;
    logic [SW/8-1:0] ts;
    int nw, si, mi, cyc;
    bit done;
    nw = (off + len + R) / R;
    for (int k = 0; k < nw; k++) begin
      wd.push_back({$urandom, $urandom, $urandom, $urandom});
      ws.push_back(16'($urandom));
    end
    for (int j = 0; j <= len; j++) begin
      tw = wd[(off + j) / R];
      ts = ws[(off + j) / R];
      ed.push_back(tw[((off + j) % R) * MW +: MW]);
      es.push_back(ts[((off + j) % R) * (MW / 8) +: (MW / 8)]);
      el.push_back(j == len);
    end
    if (bad_wlast && nw > 1) exp_err = 1'b1;
    s_cyc.delete();
    m_cyc.delete();
    first_cyc = -1;

    @(negedge ACLK);
    cmd_valid  = 1'b1;
    cmd_len    = 8'(len);
    cmd_offset = 2'(off);
    #1;
    check({tag, "_cmd_ready"}, cmd_ready, 1);

    si = 0; mi = 0; cyc = 0; done = 1'b0;
    while (!done) begin
      @(negedge ACLK);
      if (abort_after >= 0 && mi >= abort_after) break;
      cmd_valid    = 1'b0;
      S_AXI_WVALID = (si < nw);
      S_AXI_WDATA  = (si < nw) ? wd[si] : '0;
      S_AXI_WSTRB  = (si < nw) ? ws[si] : '0;
      S_AXI_WLAST  = (si < nw) && (bad_wlast ? (si == 0) : (si == nw - 1));
      case (rmode)
        0:       M_AXI_WREADY = 1'b1;
        1:       M_AXI_WREADY = (first_cyc < 0) ? 1'b1 : ((cyc - first_cyc) % 2 == 0);
        default: M_AXI_WREADY = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (cyc == 0) check({tag, "_cmd_ready_busy"}, cmd_ready, 0);
      if (M_AXI_WVALID === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (mi < ed.size()) begin
          check($sformatf("%s_data%0d", tag, mi), M_AXI_WDATA, ed[mi]);
          check($sformatf("%s_strb%0d", tag, mi), M_AXI_WSTRB, es[mi]);
          check($sformatf("%s_last%0d", tag, mi), M_AXI_WLAST, el[mi]);
        end else begin
          check({tag, "_extra_beat"}, M_AXI_WVALID, 0);
          done = 1'b1;
        end
        if (M_AXI_WREADY && mi < ed.size()) begin
          m_cyc.push_back(cyc);
          if (el[mi]) done = 1'b1;
          mi++;
        end
      end
      if (S_AXI_WVALID && S_AXI_WREADY === 1'b1) begin
        s_cyc.push_back(cyc);
        si++;
      end
      cyc++;
      if (!done && cyc >= 400) begin
        check({tag, "_timeout_beats"}, mi, ed.size());
        done = 1'b1;
      end
    end
    n_beats = mi;
  endtask

  initial begin
    ARESET       = 1'b1;
    cmd_valid    = 1'b0;
    cmd_len      = 8'd0;
    cmd_offset   = 2'd0;
    S_AXI_WDATA  = '0;
    S_AXI_WSTRB  = '0;
    S_AXI_WLAST  = 1'b0;
    S_AXI_WVALID = 1'b0;
    M_AXI_WREADY = 1'b1;

    repeat (3) @(negedge ACLK);
    #1;
    check_reset_outputs("rst");
    @(negedge ACLK);
    ARESET = 1'b0;
    #1;
    check("cmd_ready_before_edge", cmd_ready, 0);
    @(negedge ACLK);
    #1;
    check("cmd_ready_after_edge", cmd_ready, 1);

    run_burst("b1", 3, 0, 0, 1'b0, -1);
    check("b1_s_handshakes", s_cyc.size(), 1);
    check_idle("b1");

    run_burst("b2", 5, 2, 0, 1'b0, -1);
    check("b2_s_handshakes", s_cyc.size(), 2);
    check("b2_second_load_with_a3", s_cyc[1], m_cyc[1]);
    check("b2_back_to_back", m_cyc[m_cyc.size()-1] - first_cyc + 1, 6);
    check_idle("b2");

    run_burst("b3", 0, 3, 0, 1'b0, -1);
    check("b3_beats", n_beats, 1);
    check_idle("b3");

    run_burst("b4", 3, 0, 1, 1'b0, -1);
    check("b4_total_cycles", m_cyc[m_cyc.size()-1] - first_cyc + 1, 7);
    check_idle("b4");

    for (int n = 0; n < 6; n++) begin
      run_burst($sformatf("rnd%0d", n), int'($urandom_range(0, 12)),
                int'($urandom_range(0, 3)), 2, 1'b0, -1);
      check_idle($sformatf("rnd%0d", n));
    end

    run_burst("bad", 5, 2, 0, 1'b1, -1);
    check_idle("bad");
    run_burst("good", 4, 1, 2, 1'b0, -1);
    check_idle("good");

    run_burst("abort", 7, 0, 0, 1'b0, 3);
    check("abort_beats", n_beats, 3);
    S_AXI_WVALID = 1'b0;
    #1;
    ARESET = 1'b1;
    #1;
    exp_err = 1'b0;
    check_reset_outputs("mid_rst");
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    #1;
    check("post_rst_cmd_ready", cmd_ready, 1);
    run_burst("after", 0, 0, 0, 1'b0, -1);
    check("after_beats", n_beats, 1);
    check("after_s_handshakes", s_cyc.size(), 1);
    check_idle("after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddr4_v2_2_20_w_downsizer.md
# ddr4_v2_2_20_w_downsizer

AXI write-data downsizer: accepts wide write beats on a slave-side W channel and emits them as a sequence of narrow beats on a master-side W channel. A per-burst command gives the narrow beat count and the starting sub-word offset. It is the wide-to-narrow counterpart of the upsizer packing path and sits between the wide AXI interconnect side and a narrow AXI target.

## Interface
Parameters:
- C_FAMILY, "virtex6": FPGA family; passed through to sub-modules.
- C_S_DATA_WIDTH, 128: wide input data width.
- C_M_DATA_WIDTH, 32: narrow output data width. C_S_DATA_WIDTH/C_M_DATA_WIDTH is a power of two, ≥2.
- Derived: C_RATIO = C_S_DATA_WIDTH/C_M_DATA_WIDTH; C_RATIO_LOG = log2(C_RATIO).

Ports:
- ACLK  in  1  clock. Single clock domain.
- ARESET  in  1  reset; asynchronous, active-high.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_len  in  8  number of narrow beats minus 1.
- cmd_offset  in  C_RATIO_LOG  sub-word index of the first narrow beat.
- S_AXI_WDATA  in  C_S_DATA_WIDTH  wide write data.
- S_AXI_WSTRB  in  C_S_DATA_WIDTH/8  wide strobes.
- S_AXI_WLAST  in  1  upstream last flag; checked only, never used for sequencing.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  wide beat handshake.
- M_AXI_WDATA  out  C_M_DATA_WIDTH  narrow data slice.
- M_AXI_WSTRB  out  C_M_DATA_WIDTH/8  narrow strobe slice.
- M_AXI_WLAST  out  1  last narrow beat of the burst.
- M_AXI_WVALID / M_AXI_WREADY  out/in  1  narrow beat handshake.
- wlast_err  out  1  sticky; S_AXI_WLAST disagreed with the computed last wide beat.

## Operation
- States: IDLE, ACTIVE.
- IDLE: cmd_ready=1 and S_AXI_WREADY=0. On cmd handshake, load beat_cnt=cmd_len and idx=cmd_offset, then go to ACTIVE.
- ACTIVE: cmd_ready=0.
  - A one-entry holding register (buf_data, buf_strb, buf_valid) stores the current wide beat.
  - M_AXI_WVALID=buf_valid.
  - M_AXI_WDATA/WSTRB are the slice at idx of buf_data/buf_strb.
  - M_AXI_WLAST=(beat_cnt==0).
- On each narrow handshake:
  - beat_cnt decrements.
  - idx increments modulo C_RATIO (C_RATIO-1 wraps to 0).
  - The wide beat is released when idx==C_RATIO-1 or M_AXI_WLAST.
- S_AXI_WREADY = ACTIVE & (~buf_valid | (narrow handshake & release & ~M_AXI_WLAST)). No wide beat is accepted beyond the burst's last one.
- Wide beat accepted: the holding register loads; buf_valid=1.
- Release without a simultaneous load: buf_valid=0.
- Last narrow handshake (WLAST): buf_valid=0, then return to IDLE.
- Last wide beat check: the wide beat is last when the remaining narrow beats fit in the current wide beat, i.e. beat_cnt ≤ C_RATIO-1-idx. If S_AXI_WLAST differs from this at wide handshake, wlast_err is set. It clears only on reset.
- Strobes are passed unmodified; all-zero slices are still emitted as beats.
- Reset mid-burst: all state clears immediately. The partial burst is dropped, not resumed.

## Timing
- Reset values:
  - cmd_ready=0 while ARESET is high, then 1 (IDLE) from the first clock edge after deassertion.
  - S_AXI_WREADY=0, M_AXI_WVALID=0, M_AXI_WLAST=0, wlast_err=0.
- Latency: a wide beat accepted at edge N drives M_AXI_WVALID high from edge N to N+1. Narrow outputs are fed from registers only; there is no combinational path from S_AXI to M_AXI.
- Throughput: one narrow beat per cycle across wide-beat boundaries, because load and release can happen in the same cycle.
- Command spacing: the cycle after the WLAST handshake is IDLE, so there is one bubble between bursts.
- M_AXI_WDATA/WSTRB/WLAST hold stable while M_AXI_WVALID & ~M_AXI_WREADY.
- Once asserted, M_AXI_WVALID does not drop before its handshake.

## Structure
- The shared package ddr4_v2_2_20_axi_pkg holds the log2 function and the C_RATIO / C_RATIO_LOG derivation.
- Release and last detection use ddr4_v2_2_20_comparator (carry-chain equality) as the one sub-module:
  - Instance 1: idx == C_RATIO-1.
  - Instance 2: beat_cnt == 0.
- The remaining logic (FSM, counters, holding register, slice mux) is inline.

## Test plan
All scenarios use a 128→32 configuration with wide words W[k] = {D3, D2, D1, D0}.
- len=3, offset=0, one wide beat {A3, A2, A1, A0} -> M beats A0, A1, A2, A3; WLAST only on A3; one S handshake; wlast_err=0.
- len=5, offset=2, two wide beats {A3..A0} and {B3..B0} -> A2, A3, B0, B1, B2, B3 issued back-to-back with M_AXI_WREADY=1; the second S handshake occurs in the same cycle as the A3 narrow handshake.
- len=0, offset=3, wide beat {C3..C0} -> single beat C3 with WLAST=1; return to IDLE; cmd_ready=1 one cycle later.
- len=3, offset=0, M_AXI_WREADY pattern 1,0,1,0,... -> each slice held stable during its stall cycles; beat order unchanged; total 7 cycles from first WVALID.
- len=5, offset=2, S_AXI_WLAST=1 on the first wide beat -> wlast_err=1 and stays 1 through the next correct burst.
- len=7, offset=0, ARESET pulsed after 3 narrow beats -> all outputs take reset values at once; a new command (len=0) afterwards produces exactly one beat, D0 of the new wide beat.
